pixel_frame_loader: RTL and testbench

Upstream feeder for the strand driver. It accepts a byte stream from the host interface and packs each group of three bytes into a 24-bit pixel word. It writes the words into the pixel RAM. When a full strand's worth of pixels is loaded, it hands the bank to the driver by selecting the read bank and pulsing `start_frame`. It ping-pongs between two RAM banks, so the host can fill the next frame while the driver shifts out the current one.

---
 rtl/pixel_frame_loader.sv | 163 ++++++++++++++++
 tb/tb_pixel_frame_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_loader.sv
// Packs host bytes into 24-bit pixel words and hands completed frames to the strand driver.
// Define PIXEL_FRAME_LOADER_DOUBLE_BUFFER_EN for two-bank ping-pong; otherwise a single bank is used.
module pixel_frame_loader #(
  parameter int MEM_DATA_WIDTH     = 24,
  parameter int STRAND_PARAM_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [STRAND_PARAM_WIDTH-1:0] strand_length,
  input  logic [7:0]                    byte_data,
  input  logic                          byte_valid,
  input  logic                          byte_sof,
  output logic                          byte_ready,
  output logic                          mem_wr_en,
  output logic [STRAND_PARAM_WIDTH:0]   mem_wr_addr,
  output logic [MEM_DATA_WIDTH-1:0]     mem_wr_data,
  output logic                          rd_bank,
  input  logic                          driver_busy,
  output logic                          start_frame,
  output logic [15:0]                   frame_count,
  output logic [1:0]                    state_dbg_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, COMMIT = 2'd2} state_e;

  state_e                        state_q, state_d;
  logic                          wr_bank_q, wr_bank_d;
  logic                          rd_bank_q, rd_bank_d;
  logic [STRAND_PARAM_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [STRAND_PARAM_WIDTH-1:0] len_q, len_d;
  logic [1:0]                    byte_cnt_q, byte_cnt_d;
  logic [1:0]                    guard_q, guard_d;
  logic [7:0]                    b0_q, b0_d, b1_q, b1_d;
  logic                          wr_en_q, wr_en_d;
  logic [STRAND_PARAM_WIDTH:0]   wr_addr_q, wr_addr_d;
  logic [MEM_DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                          start_q, start_d;
  logic [15:0]                   frame_cnt_q, frame_cnt_d;
  logic                          xfer;
  logic [STRAND_PARAM_WIDTH-1:0] word_idx_inc;

  // Handshake: a byte moves on a rising edge where byte_valid and byte_ready are both high.
  always_comb begin
    byte_ready = (state_q != COMMIT);
`ifndef PIXEL_FRAME_LOADER_DOUBLE_BUFFER_EN
    if (driver_busy || (guard_q != 2'd0)) byte_ready = 1'b0;
`endif
  end

  assign xfer         = byte_valid & byte_ready;
  assign word_idx_inc = word_idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    word_idx_d  = word_idx_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    guard_d     = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
    b0_d        = b0_q;
    b1_d        = b1_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    start_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE, FILL: begin
        // An SOF byte restarts the frame from either state; old words are simply overwritten.
        if (xfer && byte_sof) begin
          len_d      = strand_length;
          word_idx_d = '0;
          if (strand_length == '0) begin
            byte_cnt_d = 2'd0;
            state_d    = COMMIT;
          end else begin
            b0_d       = byte_data;
            byte_cnt_d = 2'd1;
            state_d    = FILL;
          end
        end else if (xfer && (state_q == FILL)) begin
          case (byte_cnt_q)
            2'd0: begin
              b0_d       = byte_data;
              byte_cnt_d = 2'd1;
            end
            2'd1: begin
              b1_d       = byte_data;
              byte_cnt_d = 2'd2;
            end
            default: begin
              wr_en_d    = 1'b1;
              wr_addr_d  = {wr_bank_q, word_idx_q};
              wr_data_d  = {b0_q, b1_q, byte_data};
              word_idx_d = word_idx_inc;
              byte_cnt_d = 2'd0;
              if (word_idx_inc == len_q) state_d = COMMIT;
            end
          endcase
        end
      end
      COMMIT: begin
        // guard covers the gap before the driver raises busy for the previous launch.
        if (!driver_busy && (guard_q == 2'd0)) begin
`ifdef PIXEL_FRAME_LOADER_DOUBLE_BUFFER_EN
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
`endif
          start_d     = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          guard_d     = 2'd2;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      word_idx_q  <= '0;
      len_q       <= '0;
      byte_cnt_q  <= 2'd0;
      guard_q     <= 2'd0;
      b0_q        <= 8'd0;
      b1_q        <= 8'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      start_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      word_idx_q  <= word_idx_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      guard_q     <= guard_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      start_q     <= start_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign rd_bank     = rd_bank_q;
  assign start_frame = start_q;
  assign frame_count = frame_cnt_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed bench for pixel_frame_loader; expectations follow the bank mode selected by
// PIXEL_FRAME_LOADER_DOUBLE_BUFFER_EN.
module tb_pixel_frame_loader;

`ifdef PIXEL_FRAME_LOADER_DOUBLE_BUFFER_EN
  localparam logic DB = 1'b1;
`else
  localparam logic DB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] strand_length;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_sof;
  logic        byte_ready;
  logic        mem_wr_en;
  logic [16:0] mem_wr_addr;
  logic [23:0] mem_wr_data;
  logic        rd_bank;
  logic        driver_busy;
  logic        start_frame;
  logic [15:0] frame_count;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int errors  = 0;

  pixel_frame_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .strand_length(strand_length),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_sof     (byte_sof),
    .byte_ready   (byte_ready),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .rd_bank      (rd_bank),
    .driver_busy  (driver_busy),
    .start_frame  (start_frame),
    .frame_count  (frame_count),
    .state_dbg_o  (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns on the falling edge after the transfer edge.
  task automatic send(input logic [7:0] d, input logic sof);
    int n;
    byte_data  = d;
    byte_sof   = sof;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      errors++;
      $error("FAIL send_timeout observed=%0d expected=<50", n);
    end
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    strand_length = 16'd2;
    byte_data     = 8'h00;
    byte_valid    = 1'b0;
    byte_sof      = 1'b0;
    driver_busy   = 1'b0;
    idle(2);
    check("rst_wr_en",  32'(mem_wr_en),   32'd0);
    check("rst_addr",   32'(mem_wr_addr), 32'd0);
    check("rst_data",   32'(mem_wr_data), 32'd0);
    check("rst_rdbank", 32'(rd_bank),     32'd0);
    check("rst_start",  32'(start_frame), 32'd0);
    check("rst_fcount", 32'(frame_count), 32'd0);
    check("rst_ready",  32'(byte_ready),  32'd1);
    rst_n = 1'b1;
    idle(1);

    // Frame A into bank 0
    send(8'h11, 1'b1); send(8'h22, 1'b0);
    check("a_nowrite", 32'(mem_wr_en), 32'd0);
    send(8'h33, 1'b0);
    check("a0_wr_en", 32'(mem_wr_en),   32'd1);
    check("a0_addr",  32'(mem_wr_addr), 32'h00000);
    check("a0_data",  32'(mem_wr_data), 32'h112233);
    idle(1);
    check("a0_wr_pulse", 32'(mem_wr_en), 32'd0);
    send(8'h44, 1'b1 ^ 1'b1); send(8'h55, 1'b0); send(8'h66, 1'b0);
    check("a1_wr_en",     32'(mem_wr_en),   32'd1);
    check("a1_addr",      32'(mem_wr_addr), 32'h00001);
    check("a1_data",      32'(mem_wr_data), 32'h445566);
    check("a_commit_rdy", 32'(byte_ready),  32'd0);
    idle(1);
    check("a_start",  32'(start_frame), 32'd1);
    check("a_rdbank", 32'(rd_bank),     32'd0);
    check("a_fcount", 32'(frame_count), 32'd1);
    idle(1);
    check("a_start_pulse", 32'(start_frame), 32'd0);
    idle(2);

    // Frame B while the driver is busy with A
    driver_busy = 1'b1;
    idle(1);
    check("b_ready_busy", 32'(byte_ready), 32'(DB));
    if (!DB) driver_busy = 1'b0;
    send(8'h01, 1'b1); send(8'h02, 1'b0); send(8'h03, 1'b0);
    check("b0_addr", 32'(mem_wr_addr), {15'd0, DB, 16'h0000});
    check("b0_data", 32'(mem_wr_data), 32'h010203);
    send(8'h04, 1'b0); send(8'h05, 1'b0); send(8'h06, 1'b0);
    driver_busy = 1'b1;
    check("b1_wr_en", 32'(mem_wr_en),   32'd1);
    check("b1_addr",  32'(mem_wr_addr), {15'd0, DB, 16'h0001});
    check("b1_data",  32'(mem_wr_data), 32'h040506);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("b_hold_start", 32'(start_frame), 32'd0);
      check("b_hold_ready", 32'(byte_ready),  32'd0);
    end
    driver_busy = 1'b0;
    idle(1);
    check("b_start",  32'(start_frame), 32'd1);
    check("b_rdbank", 32'(rd_bank),     32'(DB));
    check("b_fcount", 32'(frame_count), 32'd2);

    // Restart mid-frame on a new SOF
    send(8'h01, 1'b1); send(8'h02, 1'b0); send(8'h03, 1'b0);
    check("r0_addr", 32'(mem_wr_addr), 32'h00000);
    check("r0_data", 32'(mem_wr_data), 32'h010203);
    send(8'h04, 1'b0);
    check("r_partial_nowrite", 32'(mem_wr_en), 32'd0);
    send(8'hAA, 1'b1); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
    check("r1_wr_en", 32'(mem_wr_en),   32'd1);
    check("r1_addr",  32'(mem_wr_addr), 32'h00000);
    check("r1_data",  32'(mem_wr_data), 32'hAABBCC);
    send(8'hDD, 1'b0); send(8'hEE, 1'b0); send(8'hFF, 1'b0);
    check("r2_addr", 32'(mem_wr_addr), 32'h00001);
    check("r2_data", 32'(mem_wr_data), 32'hDDEEFF);
    idle(1);
    check("r_start",  32'(start_frame), 32'd1);
    check("r_rdbank", 32'(rd_bank),     32'd0);
    check("r_fcount", 32'(frame_count), 32'd3);

    // Bytes without SOF in IDLE are dropped
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h30 + i), 1'b0);
      check("nosof_wr_en", 32'(mem_wr_en),   32'd0);
      check("nosof_start", 32'(start_frame), 32'd0);
    end
    check("nosof_ready",  32'(byte_ready),  32'd1);
    check("nosof_fcount", 32'(frame_count), 32'd3);

    // Zero-length frame commits straight away
    strand_length = 16'd0;
    send(8'h77, 1'b1);
    check("z_wr_en",  32'(mem_wr_en),   32'd0);
    check("z_start0", 32'(start_frame), 32'd0);
    idle(1);
    check("z_start",  32'(start_frame), 32'd1);
    check("z_wr_en1", 32'(mem_wr_en),   32'd0);
    check("z_rdbank", 32'(rd_bank),     32'(DB));
    check("z_fcount", 32'(frame_count), 32'd4);
    idle(3);

    // Reset in the middle of a frame
    strand_length = 16'd2;
    send(8'h01, 1'b1); send(8'h02, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_wr_en",  32'(mem_wr_en),   32'd0);
    check("mr_addr",   32'(mem_wr_addr), 32'd0);
    check("mr_data",   32'(mem_wr_data), 32'd0);
    check("mr_rdbank", 32'(rd_bank),     32'd0);
    check("mr_start",  32'(start_frame), 32'd0);
    check("mr_fcount", 32'(frame_count), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    send(8'h03, 1'b0);
    check("mr_drop_nowrite", 32'(mem_wr_en), 32'd0);
    send(8'hA1, 1'b1); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
    check("mr_new_wr_en", 32'(mem_wr_en),   32'd1);
    check("mr_new_addr",  32'(mem_wr_addr), 32'h00000);
    check("mr_new_data",  32'(mem_wr_data), 32'hA1A2A3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
